// File: rtl/hwag_angle_channel_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hwag_angle_channel_if
// Brief    : Angle-bus, shadow-config and channel status bundle.
// Revision : 1.0
// ============================================================================
interface hwag_angle_channel_if #(
    parameter int ANGLE_W = 12,
    parameter int LIMIT_W = 24
);
    logic               hwag_start;
    logic               gap_point;
    logic [ANGLE_W-1:0] angle;
    logic               cfg_we;
    logic [1:0]         cfg_sel;
    logic [LIMIT_W-1:0] cfg_data;
    logic               out;
    logic [ANGLE_W-1:0] active_on;
    logic [ANGLE_W-1:0] active_off;
    logic               fault;

    modport master (
        output hwag_start, gap_point, angle, cfg_we, cfg_sel, cfg_data,
        input  out, active_on, active_off, fault
    );

    modport slave (
        input  hwag_start, gap_point, angle, cfg_we, cfg_sel, cfg_data,
        output out, active_on, active_off, fault
    );
endinterface
`default_nettype wire

// File: rtl/hwag_angle_channel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hwag_angle_channel
// Brief    : One timed pulse per revolution between on/off angles, with a
//            clock-count safety limit and gap-synchronous config update.
// Revision : 1.0
// ============================================================================
module hwag_angle_channel #(
    parameter int ANGLE_W   = 12,
    parameter int ANGLE_MAX = 3839,
    parameter int LIMIT_W   = 24
) (
    input  wire logic          clk,
    input  wire logic          rst,
    hwag_angle_channel_if.slave bus
);
    localparam logic [ANGLE_W-1:0] C_ANGLE_MAX = ANGLE_W'(ANGLE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OFF  = 2'd1,
        ST_ON   = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_out;
    logic               r_fault;
    logic [LIMIT_W-1:0] r_cnt;

    logic [ANGLE_W-1:0] r_sh_on, r_sh_off, r_act_on, r_act_off;
    logic [LIMIT_W-1:0] r_sh_limit, r_act_limit;
    logic               r_sh_en, r_act_en;
    logic               r_gap_q;
    logic [ANGLE_W-1:0] r_prev_angle;

    logic               w_copy;
    logic               w_eval;
    logic               w_on_x;
    logic               w_off_x;
    logic [LIMIT_W-1:0] w_cnt_next;
    logic               w_limit_hit;
    logic               w_fault_clr;

    // Target counts as crossed if it lies in the half-open arc (prev, cur],
    // walking forward through the 3839->0 wrap when cur is behind prev.
    function automatic logic crossed(input logic [ANGLE_W-1:0] t,
                                     input logic [ANGLE_W-1:0] prev,
                                     input logic [ANGLE_W-1:0] cur);
        logic res;
        if (t > C_ANGLE_MAX)
            res = 1'b0;
        else if (prev < cur)
            res = (t > prev) && (t <= cur);
        else
            res = (t > prev) || (t <= cur);
        return res;
    endfunction

    assign w_copy      = !bus.hwag_start || (bus.gap_point && !r_gap_q);
    assign w_eval      = bus.hwag_start && (r_state != ST_IDLE) && (bus.angle != r_prev_angle);
    assign w_on_x      = w_eval && crossed(r_act_on, r_prev_angle, bus.angle);
    assign w_off_x     = w_eval && crossed(r_act_off, r_prev_angle, bus.angle);
    assign w_cnt_next  = (r_cnt == {LIMIT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
    assign w_limit_hit = (r_act_limit != '0) && (w_cnt_next == r_act_limit);
    assign w_fault_clr = bus.cfg_we && (bus.cfg_sel == 2'd3);

    // Shadow, active and angle-history registers. The copy reads the shadow
    // values before this cycle's write lands, deferring a coincident write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_on      <= '0;
            r_sh_off     <= '0;
            r_sh_limit   <= '0;
            r_sh_en      <= 1'b0;
            r_act_on     <= '0;
            r_act_off    <= '0;
            r_act_limit  <= '0;
            r_act_en     <= 1'b0;
            r_gap_q      <= 1'b0;
            r_prev_angle <= '0;
        end else begin
            r_gap_q <= bus.gap_point;
            if (bus.hwag_start)
                r_prev_angle <= bus.angle;
            if (w_copy) begin
                r_act_on    <= r_sh_on;
                r_act_off   <= r_sh_off;
                r_act_limit <= r_sh_limit;
                r_act_en    <= r_sh_en;
            end
            if (bus.cfg_we) begin
                case (bus.cfg_sel)
                    2'd0:    r_sh_on    <= bus.cfg_data[ANGLE_W-1:0];
                    2'd1:    r_sh_off   <= bus.cfg_data[ANGLE_W-1:0];
                    2'd2:    r_sh_limit <= bus.cfg_data;
                    default: if (!bus.cfg_data[1]) r_sh_en <= bus.cfg_data[0];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_out   <= 1'b0;
            r_cnt   <= '0;
            r_fault <= 1'b0;
        end else begin
            if (w_fault_clr)
                r_fault <= 1'b0;
            if (!bus.hwag_start || !r_act_en) begin
                r_state <= ST_IDLE;
                r_out   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_OFF;
                        r_out   <= 1'b0;
                    end
                    ST_OFF: begin
                        if (w_on_x && !w_off_x) begin
                            r_state <= ST_ON;
                            r_out   <= 1'b1;
                            r_cnt   <= '0;
                        end
                    end
                    ST_ON: begin
                        r_cnt <= w_cnt_next;
                        if (w_off_x) begin
                            r_state <= ST_OFF;
                            r_out   <= 1'b0;
                        end else if (w_limit_hit) begin
                            r_state <= ST_OFF;
                            r_out   <= 1'b0;
                            r_fault <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_out   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.out        = r_out;
    assign bus.fault      = r_fault;
    assign bus.active_on  = r_act_on;
    assign bus.active_off = r_act_off;

endmodule
`default_nettype wire

// File: doc/hwag_angle_channel.md
Name: hwag_angle_channel

Overview:
- Downstream consumer of the angle generator: converts the running angle count (0..3839; 60 teeth x 64 sub-steps) into one timed output pulse per revolution, e.g. one ignition dwell or one injector drive.
- Output asserts when the angle crosses a programmable on-angle and deasserts at a programmable off-angle, with a clock-count safety limit.
- Configuration is double-buffered and applied only at the gap so a pulse is never torn mid-revolution.

Parameters:
ANGLE_W, 12, angle bus width
ANGLE_MAX, 3839, last angle value before wrap to 0
LIMIT_W, 24, width of the on-time safety counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
hwag_start  input  1  angle generator synchronised; angle valid while high
gap_point  input  1  level from angle generator, high around the missing-tooth gap
angle  input  ANGLE_W  current angle count
cfg_we  input  1  write strobe for shadow config, one clk
cfg_sel  input  2  0=on_angle, 1=off_angle, 2=limit (low LIMIT_W bits), 3=enable (bit 0)
cfg_data  input  LIMIT_W  write data; angles use low ANGLE_W bits
out  output  1  channel drive, registered
active_on  output  ANGLE_W  on-angle currently in use
active_off  output  ANGLE_W  off-angle currently in use
fault  output  1  sticky: pulse was terminated by the safety limit

Behaviour:
- Reset, asynchronous: out=0, fault=0, state IDLE, all shadow and active registers 0, prev_angle 0, limit counter 0.
- Shadow registers are written on cfg_we at the next clk edge. A write with cfg_sel=3 also clears fault; if cfg_data bit 1 is 1 in that write, fault is cleared without changing enable.
- Shadow-to-active copy (on, off, limit, enable, all together) happens:
  - on the clk after a gap_point rising edge, detected with a registered gap_point, or
  - on every clk while hwag_start=0.
  - A cfg_we in the same cycle as the copy is copied on the next copy event, not this one.
- prev_angle register: loaded with angle every clk while hwag_start=1.
- Crossing of target T, evaluated only when hwag_start=1, state!=IDLE and angle!=prev_angle:
  - if prev_angle<angle: prev_angle<T<=angle.
  - otherwise (wrap): T>prev_angle or T<=angle.
  - This tolerates multi-step jumps when the angle generator reloads at a tooth.
- Targets >ANGLE_MAX never cross.
- FSM states: IDLE, OFF, ON. out=1 exactly in ON, registered.
  - IDLE->OFF: hwag_start=1 and active enable=1. prev_angle is loaded that cycle and no crossing is evaluated.
  - OFF->ON: on-angle crossed and off-angle not crossed in the same step. If both are crossed, stay OFF (no pulse). active_on==active_off never fires.
  - ON->OFF: off-angle crossed. Off wins over on if both are crossed.
  - ON->OFF: limit counter reaches active limit, which also sets fault. limit=0 disables the safety limit.
  - Any state->IDLE: hwag_start=0 or active enable=0. Forces out=0 next edge. From ON this is not a fault.
- Limit counter: cleared on OFF->ON, +1 per clk in ON, saturates at all-ones.
- Wrap windows (on>off, e.g. on=3800, off=100) are legal; the pulse spans the 3839->0 wrap.
- Latency: out changes on the clk edge that first samples the crossing angle, i.e. 1 clk after the angle bus update.

Test Plan:
1. Reset mid-pulse: channel in ON with out=1, assert rst -> out=0 and fault=0 immediately (asynchronous); after release, state IDLE until hwag_start=1.
2. Basic window: cfg on=640, off=1280, enable=1, then pulse gap_point; sweep angle 0..3839 by 1 -> out=1 from the clk sampling 640 through the clk before sampling 1280; exactly one pulse per revolution.
3. Wrap and jump: on=3800, off=100; angle steps 3790->3805 (jump), later 3839->0->...->100 -> out rises at 3805, falls at 100.
4. Shadow timing: while out is active, write off=2000 -> active_off unchanged and the current pulse ends at the old off-angle; after the next gap_point rise, active_off=2000.
5. Safety limit: limit=50, off-angle never reached -> out=1 for exactly 50 clks, then out=0 and fault=1; cfg write sel=3 with data=3 (enable kept 1, fault clear) -> fault=0.
6. Sync loss: out=1, drop hwag_start -> out=0 next edge, fault stays 0. Set on=off=500 -> no pulse over a full revolution.
